sample_reader: RTL and testbench

SAMPLE_READER -- requirements
Module: sample_reader

---
 rtl/sample_reader.sv | 149 ++++++++++++++
 tb/tb_sample_reader.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sample_reader.sv
// rtl/sample_reader.sv - streams the sample memory to a UART transmitter, one byte per handshake
// Optional trailing mod-256 checksum byte: define SAMPLE_READER_CHECKSUM_EN.
module sample_reader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  activate,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_oe,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  input  logic                  tx_active,
  input  logic                  tx_done
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SEND,
    WAIT,
    FIN
  } state_t;

  // One extra counter bit keeps the terminal compare free of a wrap-around alias.
  localparam logic [ADDR_WIDTH:0] LAST_CNT = {1'b0, {ADDR_WIDTH{1'b1}}};
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                state_q;
  logic [ADDR_WIDTH:0]   cnt_q;
  logic [ADDR_WIDTH:0]   cnt_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic                  mem_oe_q;
  logic [7:0]            tx_data_q;
  logic                  tx_start_q;
  logic                  done_q;
`ifdef SAMPLE_READER_CHECKSUM_EN
  logic [7:0]            sum_q;
  logic                  csum_q;
`endif

  assign cnt_d = cnt_q + CNT_ONE;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mem_addr_q <= '0;
      mem_oe_q   <= 1'b0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
`ifdef SAMPLE_READER_CHECKSUM_EN
      sum_q      <= '0;
      csum_q     <= 1'b0;
`endif
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (activate && !done_q) begin
            cnt_q      <= '0;
            mem_addr_q <= '0;
            mem_oe_q   <= 1'b1;
            state_q    <= FETCH;
`ifdef SAMPLE_READER_CHECKSUM_EN
            sum_q      <= '0;
            csum_q     <= 1'b0;
`endif
          end
        end
        FETCH: begin
          if (!activate) begin
            mem_oe_q <= 1'b0;
            state_q  <= IDLE;
          end else begin
            state_q  <= LOAD;
          end
        end
        // Address has been stable for a full cycle, so the async read data is settled here.
        LOAD: begin
          mem_oe_q <= 1'b0;
          if (!activate) begin
            state_q   <= IDLE;
          end else begin
            tx_data_q <= 8'(mem_data);
`ifdef SAMPLE_READER_CHECKSUM_EN
            sum_q     <= sum_q + 8'(mem_data);
`endif
            state_q   <= SEND;
          end
        end
        SEND: begin
          if (!activate) begin
            state_q    <= IDLE;
          end else if (!tx_active) begin
            tx_start_q <= 1'b1;
            state_q    <= WAIT;
          end
        end
        // A byte is in flight: leave only on tx_done, even if activate has dropped.
        WAIT: begin
          if (tx_done) begin
            if (!activate) begin
              state_q <= IDLE;
`ifdef SAMPLE_READER_CHECKSUM_EN
            end else if (csum_q) begin
              done_q  <= 1'b1;
              state_q <= FIN;
`endif
            end else if (cnt_q == LAST_CNT) begin
`ifdef SAMPLE_READER_CHECKSUM_EN
              tx_data_q <= sum_q;
              csum_q    <= 1'b1;
              state_q   <= SEND;
`else
              done_q    <= 1'b1;
              state_q   <= FIN;
`endif
            end else begin
              cnt_q      <= cnt_d;
              mem_addr_q <= cnt_d[ADDR_WIDTH-1:0];
              mem_oe_q   <= 1'b1;
              state_q    <= FETCH;
            end
          end
        end
        FIN: begin
          if (!activate) begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign done     = done_q;
  assign mem_addr = mem_addr_q;
  assign mem_oe   = mem_oe_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;

endmodule

// File: tb/tb_sample_reader.sv
// tb/tb_sample_reader.sv - directed bench for sample_reader with a 10-cycle UART model
module tb_sample_reader;

`ifdef SAMPLE_READER_CHECKSUM_EN
  localparam int         EXP_N    = 257;
  localparam logic [7:0] EXP_LAST = 8'h80;
`else
  localparam int         EXP_N    = 256;
  localparam logic [7:0] EXP_LAST = 8'hFF;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       activate;
  logic       done;
  logic [7:0] mem_addr;
  logic       mem_oe;
  logic [7:0] mem_data;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_active;
  logic       tx_done = 1'b0;

  logic [7:0] mem [256];
  logic [7:0] sent [$];
  logic       uart_busy = 1'b0;
  logic       hold_busy = 1'b0;
  logic [7:0] uart_byte = 8'h00;
  int         uart_cnt   = 0;
  int         n_start    = 0;
  int         abort_n    = -1;
  int         proto_err  = 0;
  int         stable_err = 0;
  int         checks     = 0;
  int         errors     = 0;

  always #10 clk = ~clk;

  sample_reader #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .activate (activate),
    .done     (done),
    .mem_addr (mem_addr),
    .mem_oe   (mem_oe),
    .mem_data (mem_data),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_active(tx_active),
    .tx_done  (tx_done)
  );

  // Data is garbage whenever output enable is low.
  assign mem_data  = mem_oe ? mem[mem_addr] : 8'hEE;
  assign tx_active = uart_busy | hold_busy;

  always @(negedge clk) begin
    tx_done = 1'b0;
    if (tx_start && (uart_cnt != 0 || hold_busy)) proto_err++;
    if (uart_cnt != 0) begin
      if (n_start != abort_n && tx_data !== uart_byte) stable_err++;
      uart_cnt--;
      if (uart_cnt == 0) begin
        tx_done   = 1'b1;
        uart_busy = 1'b0;
      end
    end else if (tx_start) begin
      uart_cnt  = 10;
      uart_busy = 1'b1;
      uart_byte = tx_data;
      sent.push_back(tx_data);
      n_start++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_starts(input int n, input int budget);
    int k = 0;
    while (n_start < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("wait_starts", n_start, n);
  endtask

  task automatic wait_done(input logic v, input int budget);
    int k = 0;
    while (done !== v && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("wait_done", {31'd0, done}, {31'd0, v});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_done"}, {31'd0, done}, 0);
    check({tag, "_start"}, {31'd0, tx_start}, 0);
    check({tag, "_oe"}, {31'd0, mem_oe}, 0);
    check({tag, "_addr"}, {24'd0, mem_addr}, 0);
    check({tag, "_data"}, {24'd0, tx_data}, 0);
  endtask

  task automatic check_transfer(input int base);
    int bad = 0;
    logic [7:0] exp_b;
    for (int i = 0; i < 256 && base + i < sent.size(); i++) begin
      exp_b = i[7:0];
      if (sent[base+i] !== exp_b) bad++;
    end
    check("xfer_count", n_start - base, EXP_N);
    check("xfer_order", bad, 0);
    if (base + EXP_N - 1 < sent.size())
      check("xfer_last", {24'd0, sent[base+EXP_N-1]}, {24'd0, EXP_LAST});
    check("proto", proto_err, 0);
    check("stable", stable_err, 0);
    check("fin_oe", {31'd0, mem_oe}, 0);
  endtask

  initial begin
    int base;
    for (int i = 0; i < 256; i++) mem[i] = i[7:0];
    reset    = 1'b0;
    activate = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");

    // Full transfer, with the transmitter held busy before byte 5.
    reset    = 1'b1;
    activate = 1'b1;
    wait_starts(5, 200);
    hold_busy = 1'b1;
    repeat (50) @(negedge clk);
    check("hold_no_start", n_start, 5);
    check("hold_data", {24'd0, tx_data}, 32'h05);
    hold_busy = 1'b0;
    wait_starts(6, 50);
    check("byte5", {24'd0, sent[5]}, 32'h05);
    wait_done(1'b1, 6000);
    check_transfer(0);

    repeat (40) @(negedge clk);
    check("done_held", {31'd0, done}, 1);
    check("no_rerun", n_start, EXP_N);

    activate = 1'b0;
    repeat (2) @(negedge clk);
    check("done_clear", {31'd0, done}, 0);

    // Fresh transfer, reset pulsed while byte 100 is on the wire.
    activate = 1'b1;
    base = n_start;
    wait_starts(base + 101, 2500);
    abort_n = n_start;
    reset   = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    reset = 1'b1;
    base  = n_start;
    @(negedge clk);
    check("restart_oe", {31'd0, mem_oe}, 1);
    check("restart_addr", {24'd0, mem_addr}, 0);
    wait_done(1'b1, 6000);
    check_transfer(base);

    // Abort after the third start.
    activate = 1'b0;
    wait_done(1'b0, 10);
    base = n_start;
    activate = 1'b1;
    wait_starts(base + 3, 200);
    activate = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_count", n_start - base, 3);
    check("abort_byte2", {24'd0, sent[base+2]}, 32'h02);
    check("abort_done", {31'd0, done}, 0);
    check("abort_oe", {31'd0, mem_oe}, 0);
    check("abort_uart_idle", {31'd0, tx_active}, 0);
    check("abort_proto", proto_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
